// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: FSM state encoding, legal parameter
// ranges and the parity helper used by both directions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int CLK_DIV_DEFAULT = 234;
  localparam int CLK_DIV_MIN     = 8;
  localparam int DATA_BITS_MIN   = 5;
  localparam int DATA_BITS_MAX   = 8;
  localparam int STOP_BITS_MIN   = 1;
  localparam int STOP_BITS_MAX   = 2;
  localparam int IDX_W           = 4;

  // Unused upper bits are zero, so they do not disturb the reduction.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLK_DIV-1 and wraps, with synchronous clear,
// a half-bit strobe (CLK_DIV/2 cycles after clear) and a full-bit strobe.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_half,
  output logic o_full
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_full) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_half = (r_cnt == HALF_CNT);
  assign o_full = (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with valid/ready byte streams and RX error pulses.
// Optional parity (append on TX, check on RX) is enabled by defining UART_PARITY_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_uart_rx,
  output logic                 o_uart_tx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_overrun
);

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  // ---------------- TX ----------------
  uart_state_e          r_tx_state, w_tx_state_next;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
  logic [IDX_W-1:0]     r_tx_idx, w_tx_idx_next;
  logic                 r_tx_line, w_tx_line_next;
  logic                 w_tx_clear, w_tx_half, w_tx_full;

  assign w_tx_clear = (r_tx_state == ST_IDLE);

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_tx_clear),
    .o_half (w_tx_half),
    .o_full (w_tx_full)
  );

`ifdef UART_PARITY_EN
  logic r_tx_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_par <= 1'b0;
    end else if (r_tx_state == ST_IDLE && i_tx_valid) begin
      r_tx_par <= parity_bit(DATA_BITS_MAX'(i_tx_data), 1'(PARITY_ODD));
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_line  <= w_tx_line_next;
    end
  end

  // The line value is computed alongside the next state so the pin is a flop.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_shift_next = r_tx_shift;
    w_tx_idx_next   = r_tx_idx;
    w_tx_line_next  = r_tx_line;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_line_next = 1'b1;
        if (i_tx_valid) begin
          w_tx_state_next = ST_START;
          w_tx_shift_next = i_tx_data;
          w_tx_idx_next   = '0;
          w_tx_line_next  = 1'b0;
        end
      end
      ST_START: begin
        if (w_tx_full) begin
          w_tx_state_next = ST_DATA;
          w_tx_line_next  = r_tx_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tx_full) begin
          if (r_tx_idx == LAST_DATA) begin
            w_tx_idx_next   = '0;
`ifdef UART_PARITY_EN
            w_tx_state_next = ST_PARITY;
            w_tx_line_next  = r_tx_par;
`else
            w_tx_state_next = ST_STOP;
            w_tx_line_next  = 1'b1;
`endif
          end else begin
            w_tx_idx_next   = r_tx_idx + 1'b1;
            w_tx_shift_next = {1'b0, r_tx_shift[DATA_BITS-1:1]};
            w_tx_line_next  = r_tx_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_tx_full) begin
          w_tx_state_next = ST_STOP;
          w_tx_line_next  = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tx_full) begin
          if (r_tx_idx == LAST_STOP) begin
            w_tx_state_next = ST_IDLE;
            w_tx_idx_next   = '0;
          end else begin
            w_tx_idx_next = r_tx_idx + 1'b1;
          end
        end
      end
      default: begin
        w_tx_state_next = ST_IDLE;
        w_tx_line_next  = 1'b1;
      end
    endcase
  end

  assign o_uart_tx  = r_tx_line;
  assign o_tx_ready = (r_tx_state == ST_IDLE);

  // ---------------- RX ----------------
  logic                 r_rx_meta, r_rx_sync;
  uart_state_e          r_rx_state, w_rx_state_next;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_next;
  logic [IDX_W-1:0]     r_rx_idx, w_rx_idx_next;
  logic                 w_rx_clear, w_rx_half, w_rx_full;
  logic                 w_rx_done, w_rx_frame_bad;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_rx_clear),
    .o_half (w_rx_half),
    .o_full (w_rx_full)
  );

`ifdef UART_PARITY_EN
  logic r_rx_par_bad, w_rx_par_bad, r_parity_err;

  assign w_rx_par_bad = (r_rx_state == ST_PARITY) && w_rx_full &&
                        (r_rx_sync != parity_bit(DATA_BITS_MAX'(r_rx_shift), 1'(PARITY_ODD)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_par_bad <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_rx_par_bad;
      if (r_rx_state == ST_PARITY && w_rx_full) begin
        r_rx_par_bad <= w_rx_par_bad;
      end
    end
  end

  assign o_rx_parity_err = r_parity_err;
`else
  assign o_rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_shift <= '0;
      r_rx_idx   <= '0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_idx   <= w_rx_idx_next;
    end
  end

  // Timer restarts at the verified start-bit centre so full strobes land mid-bit.
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_shift_next = r_rx_shift;
    w_rx_idx_next   = r_rx_idx;
    w_rx_clear      = 1'b0;
    w_rx_done       = 1'b0;
    w_rx_frame_bad  = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_clear = 1'b1;
        if (!r_rx_sync) begin
          w_rx_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_rx_half) begin
          if (r_rx_sync) begin
            w_rx_state_next = ST_IDLE;
          end else begin
            w_rx_state_next = ST_DATA;
            w_rx_clear      = 1'b1;
            w_rx_idx_next   = '0;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_full) begin
          w_rx_shift_next = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_idx == LAST_DATA) begin
            w_rx_idx_next = '0;
`ifdef UART_PARITY_EN
            w_rx_state_next = ST_PARITY;
`else
            w_rx_state_next = ST_STOP;
`endif
          end else begin
            w_rx_idx_next = r_rx_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_rx_full) begin
          w_rx_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_rx_full) begin
          if (r_rx_sync) begin
            w_rx_state_next = ST_IDLE;
`ifdef UART_PARITY_EN
            w_rx_done = !r_rx_par_bad;
`else
            w_rx_done = 1'b1;
`endif
          end else begin
            w_rx_state_next = ST_BREAK;
            w_rx_frame_bad  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        w_rx_clear = 1'b1;
        if (r_rx_sync) begin
          w_rx_state_next = ST_IDLE;
        end
      end
      default: begin
        w_rx_state_next = ST_IDLE;
      end
    endcase
  end

  // A same-cycle consume frees the holding register for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_rx_frame_bad;
      r_overrun   <= 1'b0;
      if (w_rx_done) begin
        if (r_rx_valid && !i_rx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data      = r_rx_data;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_frame_err = r_frame_err;
  assign o_rx_overrun   = r_overrun;

endmodule
